// File: rtl/writeback_queue.sv
// Writeback stage: formats load data, then buffers {dest, value} results in a small FIFO.
// The register-file port drains the FIFO, and the head entry is exposed for forwarding.
module writeback_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_dest,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [1:0]        in_addr_lo,
    output logic              rf_we,
    output logic [4:0]        rf_dest,
    output logic [DATA_W-1:0] rf_value,
    input  logic              rf_ready,
    output logic              fwd_valid,
    output logic [4:0]        fwd_dest,
    output logic [DATA_W-1:0] fwd_value,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [1:0] KIND_ALU   = 2'b01;
    localparam logic [1:0] KIND_LOAD  = 2'b10;
    localparam logic [1:0] KIND_STORE = 2'b11;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [4:0]        fwd_dest_q, fwd_dest_d;
    logic [DATA_W-1:0] fwd_value_q, fwd_value_d;

    logic [4:0]        dest_all  [DEPTH];
    logic [DATA_W-1:0] value_all [DEPTH];

    logic [7:0]        lane8;
    logic [15:0]       lane16;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] enq_value;

    logic              head_valid;
    logic [4:0]        head_dest;
    logic [DATA_W-1:0] head_value;
    logic              full;
    logic              accept;
    logic              push;
    logic              store_acc;
    logic              pop;
    logic              commit;

    // Load lane selection and extension, done once at enqueue.
    always_comb begin
        lane8 = in_data[7:0];
        case (in_addr_lo)
            2'd0: lane8 = in_data[7:0];
            2'd1: lane8 = in_data[15:8];
            2'd2: lane8 = in_data[23:16];
            2'd3: lane8 = in_data[31:24];
            default: lane8 = in_data[7:0];
        endcase
        lane16 = in_addr_lo[1] ? in_data[31:16] : in_data[15:0];

        case (in_size)
            2'b00: begin
                load_value       = {DATA_W{in_signed & lane8[7]}};
                load_value[7:0]  = lane8;
            end
            2'b01: begin
                load_value       = {DATA_W{in_signed & lane16[15]}};
                load_value[15:0] = lane16;
            end
            default: begin
                load_value       = {DATA_W{in_signed & in_data[31]}};
                load_value[31:0] = in_data[31:0];
            end
        endcase

        enq_value = (in_kind == KIND_ALU) ? in_result : load_value;
    end

    // Handshake and FIFO control.
    always_comb begin
        head_valid = (occ_q != '0);
        head_dest  = dest_all[rd_ptr_q];
        head_value = value_all[rd_ptr_q];
        full       = (occ_q == OCC_W'(DEPTH));
        accept     = in_valid && !full;
        push       = accept && ((in_kind == KIND_ALU) || (in_kind == KIND_LOAD));
        store_acc  = accept && (in_kind == KIND_STORE);
        // A dest-0 head never reaches the register file; it simply drains.
        pop        = head_valid && ((head_dest == 5'd0) || rf_ready);
        commit     = head_valid && (head_dest != 5'd0) && rf_ready;
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        retire_d = retire_q + CNT_W'(commit) + CNT_W'(store_acc);
    end

    // Forwarding registers remember the last valid head so they hold when the head drops.
    always_comb begin
        fwd_dest_d  = fwd_dest_q;
        fwd_value_d = fwd_value_q;
        if (head_valid && (head_dest != 5'd0)) begin
            fwd_dest_d  = head_dest;
            fwd_value_d = head_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            retire_q    <= '0;
            fwd_dest_q  <= '0;
            fwd_value_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            retire_q    <= retire_d;
            fwd_dest_q  <= fwd_dest_d;
            fwd_value_q <= fwd_value_d;
        end
    end

    // FIFO storage: one register pair per entry, written only at the write pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [4:0]        ent_dest_q, ent_dest_d;
        logic [DATA_W-1:0] ent_value_q, ent_value_d;

        always_comb begin
            ent_dest_d  = ent_dest_q;
            ent_value_d = ent_value_q;
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                ent_dest_d  = in_dest;
                ent_value_d = enq_value;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                ent_dest_q  <= '0;
                ent_value_q <= '0;
            end else begin
                ent_dest_q  <= ent_dest_d;
                ent_value_q <= ent_value_d;
            end
        end

        assign dest_all[gi]  = ent_dest_q;
        assign value_all[gi] = ent_value_q;
    end

    assign in_ready     = !full;
    assign rf_we        = head_valid && (head_dest != 5'd0);
    assign rf_dest      = head_valid ? head_dest  : '0;
    assign rf_value     = head_valid ? head_value : '0;
    assign fwd_valid    = head_valid && (head_dest != 5'd0);
    assign fwd_dest     = fwd_valid ? head_dest  : fwd_dest_q;
    assign fwd_value    = fwd_valid ? head_value : fwd_value_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = '0;
    logic [4:0]    in_dest = '0;
    logic [DW-1:0] in_result = '0;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_size = '0;
    logic          in_signed = 1'b0;
    logic [1:0]    in_addr_lo = '0;
    logic          rf_we;
    logic [4:0]    rf_dest;
    logic [DW-1:0] rf_value;
    logic          rf_ready = 1'b1;
    logic          fwd_valid;
    logic [4:0]    fwd_dest;
    logic [DW-1:0] fwd_value;
    logic [CW-1:0] retire_count;

    writeback_queue #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_dest(in_dest),
        .in_result(in_result), .in_data(in_data), .in_size(in_size), .in_signed(in_signed),
        .in_addr_lo(in_addr_lo),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_value(rf_value), .rf_ready(rf_ready),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value),
        .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending writes plus a retire counter.
    typedef struct {
        logic [4:0]  dest;
        logic [31:0] value;
    } ent_t;

    ent_t        q[$];
    int          m_cnt = 0;
    logic [4:0]  m_fdest = '0;
    logic [31:0] m_fval = '0;
    bit          m_hv, m_we, m_pop, m_rdy, m_acc;

    function automatic logic [31:0] fmt(input logic [1:0] kind, input logic [31:0] res,
                                        input logic [31:0] data, input logic [1:0] size,
                                        input logic sgn, input logic [1:0] addr);
        int unsigned lane, bits;
        if (kind == 2'b01) return res;
        case (size)
            2'b00: begin bits = 8;  lane = (data >> (8 * addr)) & 32'hFF; end
            2'b01: begin bits = 16; lane = (data >> (addr[1] ? 16 : 0)) & 32'hFFFF; end
            default: return data;
        endcase
        if (sgn && lane >= (32'd1 << (bits - 1))) return lane - (32'd1 << bits);
        return lane;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_cnt   = 0;
            m_fdest = '0;
            m_fval  = '0;
        end else begin
            m_hv  = q.size() > 0;
            m_we  = m_hv && (q[0].dest != 0);
            m_pop = m_hv && ((q[0].dest == 0) || rf_ready);
            m_rdy = q.size() < DEPTH;
            m_acc = in_valid && m_rdy;
            m_cnt = (m_cnt + int'(m_we && rf_ready) + int'(m_acc && in_kind == 2'b11)) % (1 << CW);
            if (m_pop) void'(q.pop_front());
            if (m_acc && (in_kind == 2'b01 || in_kind == 2'b10))
                q.push_back('{in_dest, fmt(in_kind, in_result, in_data, in_size, in_signed, in_addr_lo)});
            if (q.size() > 0 && q[0].dest != 0) begin
                m_fdest = q[0].dest;
                m_fval  = q[0].value;
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clock) begin
        if (reset_n && cmp_en) begin
            automatic bit exp_we = (q.size() > 0) && (q[0].dest != 0);
            check("rf_we", rf_we, exp_we);
            if (exp_we) begin
                check("rf_dest", rf_dest, q[0].dest);
                check("rf_value", rf_value, q[0].value);
            end
            check("fwd_valid", fwd_valid, exp_we);
            check("fwd_dest", fwd_dest, m_fdest);
            check("fwd_value", fwd_value, m_fval);
            check("in_ready", in_ready, q.size() < DEPTH);
            check("retire_count", retire_count, m_cnt);
        end
    end

    task automatic cyc(input logic [1:0] kind, input logic [4:0] dest, input logic [31:0] res,
                       input logic [31:0] data, input logic [1:0] size, input logic sgn,
                       input logic [1:0] addr);
        in_valid = 1'b1; in_kind = kind; in_dest = dest; in_result = res;
        in_data = data; in_size = size; in_signed = sgn; in_addr_lo = addr;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit accepted;
        int base;

        repeat (3) @(posedge clock);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_dest", rf_dest, 0);
        check("rst_rf_value", rf_value, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        check("rst_fwd_dest", fwd_dest, 0);
        check("rst_fwd_value", fwd_value, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_retire", retire_count, 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // ALU write appears one cycle after acceptance.
        cyc(2'b01, 5'd5, 32'h1234_5678, 0, 0, 0, 0);
        check("alu_we", rf_we, 1);
        check("alu_dest", rf_dest, 5);
        check("alu_value", rf_value, 32'h1234_5678);
        idle(1);
        check("alu_retire", retire_count, 1);

        // Load formatting.
        cyc(2'b10, 5'd8, 0, 32'h80FF_7F01, 2'b00, 1'b1, 2'd3);
        check("lb_signed", rf_value, 32'hFFFF_FF80);
        cyc(2'b10, 5'd8, 0, 32'h80FF_7F01, 2'b00, 1'b0, 2'd3);
        check("lb_unsigned", rf_value, 32'h0000_0080);
        cyc(2'b10, 5'd8, 0, 32'h80FF_7F01, 2'b01, 1'b1, 2'd2);
        check("lh_signed", rf_value, 32'hFFFF_80FF);
        idle(1);

        // Back-pressure: fill, hold, then drain in order.
        rf_ready = 1'b0;
        cyc(2'b01, 5'd1, 32'h11, 0, 0, 0, 0);
        cyc(2'b01, 5'd2, 32'h22, 0, 0, 0, 0);
        check("full_in_ready", in_ready, 0);
        check("full_rf_dest", rf_dest, 1);
        in_valid = 1'b1; in_kind = 2'b01; in_dest = 5'd3; in_result = 32'h33;
        idle(3);
        check("stall_rf_dest", rf_dest, 1);
        check("stall_rf_value", rf_value, 32'h11);
        rf_ready = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            accepted = in_ready;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check("stall_accept", accepted, 1);
        idle(2);
        check("drain_in_ready", in_ready, 1);
        check("drain_rf_we", rf_we, 0);

        // dest 0 drains silently, next write follows.
        cyc(2'b01, 5'd0, 32'hDEAD, 0, 0, 0, 0);
        check("r0_no_we", rf_we, 0);
        cyc(2'b10, 5'd7, 0, 32'hCAFE_BABE, 2'b10, 1'b0, 2'd1);
        check("r7_we", rf_we, 1);
        check("r7_dest", rf_dest, 7);
        check("r7_value", rf_value, 32'hCAFE_BABE);
        idle(1);

        // Store alongside a commit counts twice.
        cyc(2'b01, 5'd9, 32'h99, 0, 0, 0, 0);
        base = m_cnt;
        cyc(2'b11, 5'd0, 0, 0, 0, 0, 0);
        check("store_plus2", retire_count, (base + 2) % 16);
        idle(1);

        // Reset in the middle of a stall.
        rf_ready = 1'b0;
        cyc(2'b01, 5'd4, 32'h44, 0, 0, 0, 0);
        cyc(2'b01, 5'd6, 32'h66, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_rf_we", rf_we, 0);
        check("mid_rst_fwd_valid", fwd_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_retire", retire_count, 0);
        @(posedge clock); #1;
        reset_n  = 1'b1;
        rf_ready = 1'b1;
        idle(3);
        check("post_rst_no_write", rf_we, 0);

        // Counter wrap at CNT_W = 4.
        for (int i = 0; i < 15; i++) cyc(2'b11, 5'd0, 0, 0, 0, 0, 0);
        check("cnt_15", retire_count, 15);
        cyc(2'b11, 5'd0, 0, 0, 0, 0, 0);
        check("cnt_wrap", retire_count, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom % 4) != 0;
            in_kind    = 2'($urandom);
            in_dest    = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
            in_result  = $urandom;
            in_data    = $urandom;
            in_size    = 2'($urandom);
            in_signed  = 1'($urandom);
            in_addr_lo = 2'($urandom);
            rf_ready   = (i % 400 < 200) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        rf_ready = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
